// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: two-requester (fetch/debug) access sequencer
// for the read-only instruction memory with fixed wait states.
module imem_fetch_arbiter #(
   parameter int WAIT_CYCLES  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        FetchReq,
   input  logic [63:0] FetchAddr,
   output logic        FetchAck,
   output logic [31:0] FetchData,
   input  logic        DbgReq,
   input  logic [63:0] DbgAddr,
   output logic        DbgAck,
   output logic [31:0] DbgData,
   output logic [63:0] MemAddr,
   input  logic [31:0] MemData,
   output logic        Busy,
   output logic        Fault
);

   localparam int SCW =
      ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
   localparam int WCW =
      ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [SCW-1:0] starve_cnt;
   logic [WCW-1:0] wait_cnt;
   logic           gnt_dbg;

   logic           any_req;
   logic           dbg_win;
   logic [63:0]    win_addr;
   logic           win_misal;
   logic           last_wait;

   assign any_req   = FetchReq | DbgReq;
   assign dbg_win   = DbgReq &
                      (~FetchReq | (starve_cnt == STARVE_MAX));
   assign win_addr  = dbg_win ? DbgAddr : FetchAddr;
   assign win_misal = |win_addr[1:0];
   assign last_wait = (wait_cnt == WAIT_LAST);
   assign Busy      = (state != IDLE);

   // State register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: misaligned winners skip the memory access.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = win_misal ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (last_wait) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Grant, address, wait timing, starvation and registered responses.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         MemAddr    <= '0;
         FetchAck   <= 1'b0;
         DbgAck     <= 1'b0;
         FetchData  <= '0;
         DbgData    <= '0;
         Fault      <= 1'b0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         gnt_dbg    <= 1'b0;
      end else begin
         FetchAck <= 1'b0;
         DbgAck   <= 1'b0;
         Fault    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_dbg <= dbg_win;
                  if (!dbg_win && DbgReq) begin
                     if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     starve_cnt <= '0;
                  end
                  if (win_misal) begin
                     Fault <= 1'b1;
                     if (dbg_win) begin
                        DbgAck  <= 1'b1;
                        DbgData <= '0;
                     end else begin
                        FetchAck  <= 1'b1;
                        FetchData <= '0;
                     end
                  end else begin
                     MemAddr  <= win_addr;
                     wait_cnt <= '0;
                  end
               end
            end
            ACCESS: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (last_wait) begin
                  if (gnt_dbg) begin
                     DbgAck  <= 1'b1;
                     DbgData <= MemData;
                  end else begin
                     FetchAck  <= 1'b1;
                     FetchData <= MemData;
                  end
               end
            end
            RESP: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: directed scoreboard bench for
// imem_fetch_arbiter (default instance plus WAIT_CYCLES=1 instance).
module tb_imem_fetch_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        freq, dreq, fack, dack, busy, fault;
   logic [63:0] faddr, daddr, maddr;
   logic [31:0] fdata, ddata, mdata;

   logic        freq1, dreq1, fack1, dack1, busy1, fault1;
   logic [63:0] faddr1, daddr1, maddr1;
   logic [31:0] fdata1, ddata1, mdata1;

   function automatic logic [31:0] rom(input logic [63:0] a);
      case (a)
         64'h00:  rom = 32'hF84003E9;
         64'h08:  rom = 32'hF84103EB;
         64'h14:  rom = 32'hAA0B014A;
         64'h34:  rom = 32'hD2E24689;
         64'h50:  rom = 32'hF80283E9;
         default: rom = 32'h1000_0000 | a[31:0];
      endcase
   endfunction

   assign mdata  = rom(maddr);
   assign mdata1 = rom(maddr1);

   imem_fetch_arbiter u_dut (
      .CLK(clk), .Reset(rst),
      .FetchReq(freq), .FetchAddr(faddr),
      .FetchAck(fack), .FetchData(fdata),
      .DbgReq(dreq), .DbgAddr(daddr),
      .DbgAck(dack), .DbgData(ddata),
      .MemAddr(maddr), .MemData(mdata),
      .Busy(busy), .Fault(fault)
   );

   imem_fetch_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
      .CLK(clk), .Reset(rst),
      .FetchReq(freq1), .FetchAddr(faddr1),
      .FetchAck(fack1), .FetchData(fdata1),
      .DbgReq(dreq1), .DbgAddr(daddr1),
      .DbgAck(dack1), .DbgData(ddata1),
      .MemAddr(maddr1), .MemData(mdata1),
      .Busy(busy1), .Fault(fault1)
   );

   typedef struct {
      logic        dbg;
      logic [31:0] data;
      logic        flt;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic dbg,
                       input logic [63:0] addr,
                       input int lat);
      exp_t e;
      e.dbg  = dbg;
      e.flt  = |addr[1:0];
      e.data = e.flt ? 32'h0 : rom(addr);
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic expect_ack(input string tag);
      exp_t e;
      int   n;
      n = 1;
      step();
      while (!(fack || dack) && n < 40) begin
         step();
         n++;
      end
      e = sb.pop_front();
      chk({tag, " ack"}, 64'({dack, fack}),
          e.dbg ? 64'h2 : 64'h1);
      chk({tag, " data"}, 64'(e.dbg ? ddata : fdata),
          64'(e.data));
      chk({tag, " fault"}, 64'(fault), 64'(e.flt));
      chk({tag, " latency"}, 64'(n), 64'(e.lat));
   endtask

   initial begin
      exp_t e;
      bit   busy_exp[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      bit   ack_exp[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1;
      freq = 1'b0; dreq = 1'b0; faddr = '0; daddr = '0;
      freq1 = 1'b0; dreq1 = 1'b0; faddr1 = '0; daddr1 = '0;
      repeat (3) step();
      chk("rst memaddr", maddr, 64'h0);
      chk("rst acks", 64'({fack, dack}), 64'h0);
      chk("rst fdata", 64'(fdata), 64'h0);
      chk("rst ddata", 64'(ddata), 64'h0);
      chk("rst fault busy", 64'({fault, busy}), 64'h0);
      chk("rst dut1 busy", 64'({busy1, fack1}), 64'h0);
      rst = 1'b0;
      step();

      // basic fetch
      faddr = 64'h0; freq = 1'b1; push(1'b0, 64'h0, 3);
      expect_ack("t1 fetch 0x0");
      freq = 1'b0; step();
      faddr = 64'h14; freq = 1'b1; push(1'b0, 64'h14, 3);
      expect_ack("t1 fetch 0x14");
      freq = 1'b0; step();

      // debug path
      daddr = 64'h34; dreq = 1'b1; push(1'b1, 64'h34, 3);
      expect_ack("t2 dbg 0x34");
      chk("t2 fdata held", 64'(fdata), 64'(rom(64'h14)));
      dreq = 1'b0; step();

      // starvation
      faddr = 64'h0; daddr = 64'h50; freq = 1'b1; dreq = 1'b1;
      push(1'b0, 64'h0, 3);
      push(1'b0, 64'h4, 4);
      push(1'b0, 64'h8, 4);
      push(1'b0, 64'hC, 4);
      push(1'b1, 64'h50, 4);
      push(1'b0, 64'h10, 4);
      for (int i = 0; i < 6; i++) begin
         expect_ack("t3 starve");
         if (dack) dreq = 1'b0;
         else faddr = faddr + 64'h4;
      end
      freq = 1'b0; step();

      // misaligned
      faddr = 64'h6; freq = 1'b1; push(1'b0, 64'h6, 1);
      expect_ack("t4 misaligned");
      chk("t4 memaddr held", maddr, 64'h10);
      freq = 1'b0; step();
      chk("t4 fault cleared", 64'(fault), 64'h0);

      // reset during the first ACCESS cycle
      faddr = 64'h8; freq = 1'b1;
      step();
      chk("t5 busy pre-reset", 64'(busy), 64'h1);
      rst = 1'b1; freq = 1'b0;
      step();
      rst = 1'b0;
      chk("t5 memaddr", maddr, 64'h0);
      chk("t5 acks", 64'({fack, dack}), 64'h0);
      chk("t5 fdata", 64'(fdata), 64'h0);
      chk("t5 ddata", 64'(ddata), 64'h0);
      chk("t5 fault busy", 64'({fault, busy}), 64'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5 no ack", 64'({fack, dack}), 64'h0);
      end
      faddr = 64'h8; freq = 1'b1; push(1'b0, 64'h8, 3);
      expect_ack("t5 rerequest");
      freq = 1'b0; step();

      // WAIT_CYCLES=1 back-to-back
      faddr1 = 64'h1C; freq1 = 1'b1;
      push(1'b0, 64'h1C, 2);
      push(1'b0, 64'h20, 3);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("t6 busy", 64'(busy1), 64'(busy_exp[c]));
         chk("t6 ack", 64'({dack1, fack1}), 64'(ack_exp[c]));
         if (ack_exp[c]) begin
            e = sb.pop_front();
            chk("t6 data", 64'(fdata1), 64'(e.data));
            chk("t6 fault", 64'(fault1), 64'(e.flt));
            if (c == 1) faddr1 = 64'h20;
            else freq1 = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
